// File: rtl/seg_uart_tx_if.sv
// Handshake bundle carrying 7-segment codes into the UART transmitter.
interface seg_uart_tx_if;
    logic [6:0] seg_in;
    logic       seg_valid;
    logic       seg_ready;

    modport master (output seg_in, output seg_valid, input seg_ready);
    modport slave  (input seg_in, input seg_valid, output seg_ready);
endinterface

// File: rtl/seg_uart_tx.sv
// Decodes 7-segment digit codes to ASCII, queues them and sends each as an 8N1 UART frame.
//   state   | meaning
//   S_IDLE  | line high, waiting for a queued character
//   S_START | start bit (low) on the line
//   S_DATA  | data bits, LSB first
//   S_STOP  | stop bit (high); chains straight into the next start bit if queued
module seg_uart_tx #(
    parameter int DELAY_FRAMES = 234,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic          clk,
    input  logic          rst,
    seg_uart_tx_if.slave  seg,
    output logic          uart_tx,
    output logic          busy,
    output logic          err
);
    localparam int          AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [15:0] CNT_LAST = 16'(DELAY_FRAMES - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t      state_q;
    logic [15:0] cnt_q;
    logic [2:0]  bit_q;
    logic [7:0]  shift_q;
    logic        tx_q;
    logic        err_q;
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;

    logic        empty;
    logic        full;
    logic        push;
    logic        pop;
    logic [7:0]  head;
    logic [7:0]  ascii_d;
    logic        bad_d;

    always_comb begin
        ascii_d = 8'h3F;
        bad_d   = 1'b0;
        case (seg.seg_in)
            7'b0111111: ascii_d = 8'h30;
            7'b0001001: ascii_d = 8'h31;
            7'b1011110: ascii_d = 8'h32;
            7'b1011011: ascii_d = 8'h33;
            7'b1101001: ascii_d = 8'h34;
            7'b1110011: ascii_d = 8'h35;
            7'b1110111: ascii_d = 8'h36;
            7'b0011001: ascii_d = 8'h37;
            7'b1111111: ascii_d = 8'h38;
            7'b1111011: ascii_d = 8'h39;
            default:    bad_d   = 1'b1;
        endcase
    end

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    assign seg.seg_ready = !full;
    assign push = seg.seg_valid && !full;
    assign pop  = !empty && ((state_q == S_IDLE) ||
                             ((state_q == S_STOP) && (cnt_q == CNT_LAST)));

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q[AW-1:0]] <= ascii_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            err_q <= push && bad_d;
            case (state_q)
                S_IDLE: begin
                    tx_q <= 1'b1;
                    if (!empty) begin
                        shift_q <= head;
                        tx_q    <= 1'b0;
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q   <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= S_DATA;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        if (bit_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            tx_q    <= shift_q[1];
                            shift_q <= {1'b1, shift_q[7:1]};
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_q <= '0;
                        if (!empty) begin
                            shift_q <= head;
                            tx_q    <= 1'b0;
                            bit_q   <= '0;
                            state_q <= S_START;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign uart_tx = tx_q;
    assign err     = err_q;
    assign busy    = (state_q != S_IDLE) || !empty;
endmodule

// File: tb/tb_seg_uart_tx.sv
// Directed bench for seg_uart_tx: decode table, streaming, FIFO-full back-pressure and reset cases.
module tb_seg_uart_tx;
    localparam int D     = 4;
    localparam int DEPTH = 4;

    typedef struct {
        logic [6:0] seg;
        logic [7:0] ascii;
        logic       err;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       ok;
        int         start;
    } frame_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic uart_tx;
    logic busy;
    logic err;

    seg_uart_tx_if sif();

    seg_uart_tx #(.DELAY_FRAMES(D), .FIFO_DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .seg     (sif),
        .uart_tx (uart_tx),
        .busy    (busy),
        .err     (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int low_cnt = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (uart_tx === 1'b0) low_cnt <= low_cnt + 1;

    int n_checks = 0;
    int n_fail   = 0;
    frame_t rxq[$];
    logic [6:0] digit_seg [10];
    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Line monitor: samples every cycle of every bit; a frame is ok only if all samples agree.
    logic [7:0] mon_data;
    logic       mon_ok;
    logic       mon_abort;
    int         mon_start;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && uart_tx === 1'b0) begin
                mon_start = cyc;
                mon_ok    = 1'b1;
                mon_abort = 1'b0;
                mon_data  = 8'h00;
                for (int k = 0; k < 10 && !mon_abort; k++) begin
                    for (int c = 0; c < D && !mon_abort; c++) begin
                        if (!(k == 0 && c == 0)) @(negedge clk);
                        if (rst) begin
                            mon_abort = 1'b1;
                        end else if (k == 0) begin
                            if (uart_tx !== 1'b0) mon_ok = 1'b0;
                        end else if (k == 9) begin
                            if (uart_tx !== 1'b1) mon_ok = 1'b0;
                        end else if (c == 0) begin
                            mon_data[k-1] = uart_tx;
                        end else if (uart_tx !== mon_data[k-1]) begin
                            mon_ok = 1'b0;
                        end
                    end
                end
                if (!mon_abort) rxq.push_back('{data: mon_data, ok: mon_ok, start: mon_start});
            end
        end
    end

    task automatic wait_frames(input int n, input int budget, input string name);
        int t = 0;
        while (rxq.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk(name, 32'(rxq.size() >= n), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        int t = 0;
        while (busy !== 1'b0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk(name, 32'(busy), 32'd0);
    endtask

    task automatic pop_frame(input string name, input logic [7:0] exp, output int start);
        frame_t f;
        f = '{data: 8'hxx, ok: 1'b0, start: 0};
        if (rxq.size() > 0) f = rxq.pop_front();
        chk({name, "_data"}, 32'(f.data), 32'(exp));
        chk({name, "_ok"}, 32'(f.ok), 32'd1);
        start = f.start;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int prev;
        int n;
        int l0;
        logic saw_full;

        digit_seg[0] = 7'b0111111; digit_seg[1] = 7'b0001001;
        digit_seg[2] = 7'b1011110; digit_seg[3] = 7'b1011011;
        digit_seg[4] = 7'b1101001; digit_seg[5] = 7'b1110011;
        digit_seg[6] = 7'b1110111; digit_seg[7] = 7'b0011001;
        digit_seg[8] = 7'b1111111; digit_seg[9] = 7'b1111011;
        for (int i = 0; i < 10; i++) vecs[i] = '{seg: digit_seg[i], ascii: 8'(8'h30 + i), err: 1'b0};
        vecs[10] = '{seg: 7'b0000000, ascii: 8'h3F, err: 1'b1};
        vecs[11] = '{seg: 7'b1111110, ascii: 8'h3F, err: 1'b1};

        sif.seg_in = 7'b0;
        sif.seg_valid = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_uart_tx", 32'(uart_tx), 32'd1);
        chk("rst_seg_ready", 32'(sif.seg_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Single '3': latency, exact frame length, busy fall.
        sif.seg_in = 7'b1011011;
        sif.seg_valid = 1'b1;
        @(posedge clk); #1;
        sif.seg_valid = 1'b0;
        @(negedge clk);
        chk("single_tx_before", 32'(uart_tx), 32'd1);
        chk("single_busy_queued", 32'(busy), 32'd1);
        @(negedge clk);
        chk("single_tx_fall", 32'(uart_tx), 32'd0);
        repeat (39) @(negedge clk);
        chk("single_stop_busy", 32'(busy), 32'd1);
        chk("single_stop_tx", 32'(uart_tx), 32'd1);
        @(negedge clk);
        chk("single_busy_fall", 32'(busy), 32'd0);
        wait_frames(1, 20, "single_frame_seen");
        pop_frame("single", 8'h33, st);

        // Decode table, one code at a time.
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            sif.seg_in = vecs[i].seg;
            sif.seg_valid = 1'b1;
            @(posedge clk); #1;
            sif.seg_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].err));
            @(negedge clk);
            chk($sformatf("vec%0d_err_gone", i), 32'(err), 32'd0);
            wait_frames(1, 100, $sformatf("vec%0d_seen", i));
            pop_frame($sformatf("vec%0d", i), vecs[i].ascii, st);
            wait_idle($sformatf("vec%0d_idle", i));
        end

        // Stream 0..9 with valid held; expect contiguous frames.
        @(posedge clk); #1;
        saw_full = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sif.seg_in = digit_seg[i];
            sif.seg_valid = 1'b1;
            n = 0;
            while (!sif.seg_ready && n < 200) begin
                saw_full = 1'b1;
                @(posedge clk); #1;
                n++;
            end
            chk($sformatf("stream%0d_ready_wait", i), 32'(n < 200), 32'd1);
            @(posedge clk); #1;
        end
        sif.seg_valid = 1'b0;
        chk("stream_saw_full", 32'(saw_full), 32'd1);
        wait_frames(10, 500, "stream_frames_seen");
        prev = 0;
        for (int i = 0; i < 10; i++) begin
            pop_frame($sformatf("stream%0d", i), 8'(8'h30 + i), st);
            if (i > 0) chk($sformatf("stream%0d_gap", i), 32'(st - prev), 32'(10 * D));
            prev = st;
        end
        wait_idle("stream_idle");

        // Fill: five back-to-back pushes, sixth held until first post-fill pop.
        @(posedge clk); #1;
        sif.seg_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            sif.seg_in = digit_seg[k + 1];
            @(posedge clk); #1;
        end
        sif.seg_in = digit_seg[6];
        chk("fill_ready_low", 32'(sif.seg_ready), 32'd0);
        n = 0;
        while (!sif.seg_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("fill_ready_rise_cycles", 32'(n), 32'd37);
        @(posedge clk); #1;
        sif.seg_valid = 1'b0;
        chk("fill_full_again", 32'(sif.seg_ready), 32'd0);
        wait_frames(6, 300, "fill_frames_seen");
        prev = 0;
        for (int i = 0; i < 6; i++) begin
            pop_frame($sformatf("fill%0d", i), 8'(8'h31 + i), st);
            if (i > 0) chk($sformatf("fill%0d_gap", i), 32'(st - prev), 32'(10 * D));
            prev = st;
        end
        wait_idle("fill_idle");

        // Reset at cycle 15 of a frame with two characters queued.
        @(posedge clk); #1;
        sif.seg_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sif.seg_in = digit_seg[k + 7];
            @(posedge clk); #1;
        end
        sif.seg_valid = 1'b0;
        repeat (13) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_tx", 32'(uart_tx), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_ready", 32'(sif.seg_ready), 32'd1);
        rst = 1'b0;
        l0 = low_cnt;
        repeat (100) @(negedge clk);
        chk("midrst_no_low", 32'(low_cnt - l0), 32'd0);
        chk("midrst_no_frames", 32'(rxq.size()), 32'd0);

        // Reset together with a valid code: nothing stored.
        rst = 1'b1;
        sif.seg_in = digit_seg[5];
        sif.seg_valid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sif.seg_valid = 1'b0;
        @(negedge clk);
        chk("rstvalid_busy", 32'(busy), 32'd0);
        chk("rstvalid_ready", 32'(sif.seg_ready), 32'd1);
        chk("rstvalid_tx", 32'(uart_tx), 32'd1);
        l0 = low_cnt;
        repeat (60) @(negedge clk);
        chk("rstvalid_no_low", 32'(low_cnt - l0), 32'd0);
        chk("rstvalid_no_frames", 32'(rxq.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
